// File: rtl/output_queue_scheduler.sv
// ============================================================================
// Module  : output_queue_scheduler
// Brief   : Per-port linked-list queues over the shared cell buffer, with a
//           round-robin read scheduler that follows each cell's next pointer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module output_queue_scheduler #(
    parameter int nbrOfPorts     = 4,
    parameter int parrallelWidth = 512,
    parameter int addresses      = 32,
    parameter int addressWidth   = $clog2(addresses),
    parameter int countWidth     = $clog2(addresses + 1)
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               enqValid,
    input  logic [addressWidth-1:0]            enqAddress,
    input  logic [$clog2(nbrOfPorts)-1:0]      enqPort,
    input  logic [nbrOfPorts-1:0]              portReady,
    output logic [addressWidth-1:0]            readAddress,
    output logic                               readEnable,
    output logic [$clog2(nbrOfPorts)-1:0]      readPort,
    input  logic [parrallelWidth-1:0]          readData,
    input  logic [addressWidth-1:0]            nextReadPtr,
    output logic                               cellValid,
    output logic [$clog2(nbrOfPorts)-1:0]      cellPort,
    output logic [parrallelWidth-1:0]          cellData,
    output logic [nbrOfPorts*countWidth-1:0]   queueCount
);

    localparam int c_PW = $clog2(nbrOfPorts);

    logic [addressWidth-1:0] r_head  [nbrOfPorts];
    logic [countWidth-1:0]   r_count [nbrOfPorts];
    logic [nbrOfPorts-1:0]   r_in_flight;
    logic [nbrOfPorts-1:0]   r_last_cell;
    logic [c_PW-1:0]         r_rr_ptr;
    logic                    r_cmp_valid;
    logic [c_PW-1:0]         r_cmp_port;

    logic [nbrOfPorts-1:0]   w_enq_hit;
    logic [nbrOfPorts-1:0]   w_cmp_hit;
    logic [nbrOfPorts-1:0]   w_inc;
    logic [nbrOfPorts-1:0]   w_eligible;
    logic                    w_grant_valid;
    logic [c_PW-1:0]         w_grant;
    logic [c_PW:0]           w_sum;
    logic [c_PW-1:0]         w_idx;
    logic [c_PW-1:0]         w_rr_next;

    // A single-cell queue being appended to this cycle is held back so its
    // tail is never read while the buffer is still writing its link.
    always_comb begin
        w_enq_hit  = '0;
        w_cmp_hit  = '0;
        w_inc      = '0;
        w_eligible = '0;
        for (int p = 0; p < nbrOfPorts; p++) begin
            w_enq_hit[p]  = enqValid && (enqPort == c_PW'(p));
            w_cmp_hit[p]  = r_cmp_valid && (r_cmp_port == c_PW'(p));
            w_inc[p]      = w_enq_hit[p] && (r_count[p] != countWidth'(addresses));
            w_eligible[p] = (r_count[p] != '0) && !r_in_flight[p] && portReady[p]
                            && !((r_count[p] == countWidth'(1)) && w_enq_hit[p]);
        end
    end

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        w_sum         = '0;
        w_idx         = '0;
        for (int i = 0; i < nbrOfPorts; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_PW+1)'(i);
            if (w_sum >= (c_PW+1)'(nbrOfPorts)) begin
                w_sum = w_sum - (c_PW+1)'(nbrOfPorts);
            end
            w_idx = w_sum[c_PW-1:0];
            if (!w_grant_valid && w_eligible[w_idx]) begin
                w_grant_valid = 1'b1;
                w_grant       = w_idx;
            end
        end
    end

    assign w_rr_next   = (w_grant == c_PW'(nbrOfPorts - 1)) ? '0 : w_grant + c_PW'(1);

    assign readEnable  = w_grant_valid;
    assign readAddress = w_grant_valid ? r_head[w_grant] : '0;
    assign readPort    = w_grant_valid ? w_grant : '0;

    assign cellValid   = r_cmp_valid;
    assign cellPort    = r_cmp_port;
    assign cellData    = r_cmp_valid ? readData : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr    <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_port  <= '0;
        end else begin
            r_cmp_valid <= w_grant_valid;
            if (w_grant_valid) begin
                r_cmp_port <= w_grant;
                r_rr_ptr   <= w_rr_next;
            end
        end
    end

    // A completing last cell frees the head, so a same-cycle enqueue refills it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int p = 0; p < nbrOfPorts; p++) begin
                r_head[p]  <= '0;
                r_count[p] <= '0;
            end
            r_in_flight <= '0;
            r_last_cell <= '0;
        end else begin
            for (int p = 0; p < nbrOfPorts; p++) begin
                if (w_grant_valid && (w_grant == c_PW'(p))) begin
                    r_in_flight[p] <= 1'b1;
                    r_last_cell[p] <= (r_count[p] == countWidth'(1));
                end else if (w_cmp_hit[p]) begin
                    r_in_flight[p] <= 1'b0;
                end
                r_count[p] <= r_count[p] + countWidth'(w_inc[p]) - countWidth'(w_cmp_hit[p]);
                if (w_cmp_hit[p] && !r_last_cell[p]) begin
                    r_head[p] <= nextReadPtr;
                end else if (w_enq_hit[p] && ((r_count[p] == '0) || w_cmp_hit[p])) begin
                    r_head[p] <= enqAddress;
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < nbrOfPorts; p++) begin : g_count_out
            assign queueCount[p*countWidth +: countWidth] = r_count[p];
        end
    endgenerate

    a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
        !(enqValid && (r_count[enqPort] == countWidth'(addresses))));

endmodule

`default_nettype wire

// File: tb/tb_output_queue_scheduler.sv
// ============================================================================
// Module  : tb_output_queue_scheduler
// Brief   : Directed self-checking bench with a one-cycle-latency buffer model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_output_queue_scheduler;

    logic         clk;
    logic         rstn;
    logic         enqValid;
    logic [4:0]   enqAddress;
    logic [1:0]   enqPort;
    logic [3:0]   portReady;
    logic [4:0]   readAddress;
    logic         readEnable;
    logic [1:0]   readPort;
    logic [511:0] readData;
    logic [4:0]   nextReadPtr;
    logic         cellValid;
    logic [1:0]   cellPort;
    logic [511:0] cellData;
    logic [23:0]  queueCount;

    int checks;
    int errors;

    logic [4:0] link_mem [32];
    logic [4:0] rd_addr_q;

    output_queue_scheduler dut (
        .clk         (clk),
        .rstn        (rstn),
        .enqValid    (enqValid),
        .enqAddress  (enqAddress),
        .enqPort     (enqPort),
        .portReady   (portReady),
        .readAddress (readAddress),
        .readEnable  (readEnable),
        .readPort    (readPort),
        .readData    (readData),
        .nextReadPtr (nextReadPtr),
        .cellValid   (cellValid),
        .cellPort    (cellPort),
        .cellData    (cellData),
        .queueCount  (queueCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] cell_of(input logic [4:0] a);
        return {16{27'd12345, a}};
    endfunction

    function automatic logic [5:0] qc(input int p);
        return queueCount[p*6 +: 6];
    endfunction

    // Buffer model: data and link appear one cycle after the read address.
    always @(posedge clk) rd_addr_q <= readAddress;
    assign readData    = cell_of(rd_addr_q);
    assign nextReadPtr = link_mem[rd_addr_q];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        enqValid  = 1'b0;
        portReady = 4'hF;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        enqValid = 1'b1; enqAddress = 5'd4; enqPort = 2'd1;
        tick();
        #1;
        checks++;
        if (readEnable !== 1'b0 || readAddress !== 5'd0 || readPort !== 2'd0) begin
            errors++;
            $display("FAIL reset_read: en=%0b addr=%0d port=%0d expected 0/0/0", readEnable, readAddress, readPort);
        end
        checks++;
        if (cellValid !== 1'b0 || cellPort !== 2'd0 || cellData !== 512'd0) begin
            errors++;
            $display("FAIL reset_cell: valid=%0b port=%0d data_nonzero=%0b expected 0/0/0", cellValid, cellPort, |cellData);
        end
        checks++;
        if (queueCount !== 24'd0) begin
            errors++;
            $display("FAIL reset_counts: queueCount=%h expected 0", queueCount);
        end
        enqValid = 1'b0;
    endtask

    task automatic test_single_cell();
        do_reset();
        enqValid = 1'b1; enqAddress = 5'd5; enqPort = 2'd2;
        #1;
        checks++;
        if (readEnable !== 1'b0) begin
            errors++;
            $display("FAIL single_no_early_read: readEnable=%0b expected 0", readEnable);
        end
        tick();
        enqValid = 1'b0;
        #1;
        checks++;
        if (readEnable !== 1'b1 || readAddress !== 5'd5 || readPort !== 2'd2 || qc(2) !== 6'd1) begin
            errors++;
            $display("FAIL single_issue: en=%0b addr=%0d port=%0d cnt=%0d expected 1/5/2/1",
                     readEnable, readAddress, readPort, qc(2));
        end
        tick();
        #1;
        checks++;
        if (cellValid !== 1'b1 || cellPort !== 2'd2 || cellData !== cell_of(5'd5) || readEnable !== 1'b0) begin
            errors++;
            $display("FAIL single_deliver: valid=%0b port=%0d data_ok=%0b en=%0b expected 1/2/1/0",
                     cellValid, cellPort, cellData === cell_of(5'd5), readEnable);
        end
        tick();
        #1;
        checks++;
        if (qc(2) !== 6'd0 || cellValid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: cnt=%0d valid=%0b expected 0/0", qc(2), cellValid);
        end
    endtask

    task automatic test_linked_chain();
        logic [4:0] exp_addr [3];
        exp_addr[0] = 5'd3; exp_addr[1] = 5'd9; exp_addr[2] = 5'd12;
        do_reset();
        link_mem[3] = 5'd9;
        link_mem[9] = 5'd12;
        enqValid = 1'b1; enqAddress = 5'd3; enqPort = 2'd0;
        tick();
        enqAddress = 5'd9;
        #1;
        checks++;
        if (readEnable !== 1'b0) begin
            errors++;
            $display("FAIL chain_tail_hold: readEnable=%0b expected 0", readEnable);
        end
        tick();
        enqAddress = 5'd12;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (readEnable !== 1'b1 || readAddress !== exp_addr[k] || readPort !== 2'd0) begin
                errors++;
                $display("FAIL chain_issue%0d: en=%0b addr=%0d port=%0d expected 1/%0d/0",
                         k, readEnable, readAddress, readPort, exp_addr[k]);
            end
            tick();
            enqValid = 1'b0;
            #1;
            checks++;
            if (readEnable !== 1'b0 || cellValid !== 1'b1 || cellPort !== 2'd0 || cellData !== cell_of(exp_addr[k])) begin
                errors++;
                $display("FAIL chain_deliver%0d: en=%0b valid=%0b port=%0d data_ok=%0b expected 0/1/0/1",
                         k, readEnable, cellValid, cellPort, cellData === cell_of(exp_addr[k]));
            end
            tick();
        end
        #1;
        checks++;
        if (qc(0) !== 6'd0 || cellValid !== 1'b0) begin
            errors++;
            $display("FAIL chain_drain: cnt=%0d valid=%0b expected 0/0", qc(0), cellValid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        portReady = 4'h0;
        for (int p = 0; p < 4; p++) link_mem[16+p] = 5'(20 + p);
        for (int i = 0; i < 8; i++) begin
            enqValid   = 1'b1;
            enqPort    = 2'(i % 4);
            enqAddress = 5'((i < 4) ? 16 + i : 20 + i - 4);
            tick();
        end
        enqValid = 1'b0;
        #1;
        checks++;
        if (queueCount !== {6'd2, 6'd2, 6'd2, 6'd2} || readEnable !== 1'b0) begin
            errors++;
            $display("FAIL rr_fill: queueCount=%h en=%0b expected 082082/0", queueCount, readEnable);
        end
        portReady = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if (readEnable !== 1'b1 || readPort !== 2'(c % 4) || readAddress !== 5'(((c < 4) ? 16 : 20) + c % 4)) begin
                errors++;
                $display("FAIL rr_grant%0d: en=%0b port=%0d addr=%0d expected 1/%0d/%0d",
                         c, readEnable, readPort, readAddress, c % 4, ((c < 4) ? 16 : 20) + c % 4);
            end
            if (c > 0) begin
                checks++;
                if (cellValid !== 1'b1 || cellPort !== 2'((c - 1) % 4)) begin
                    errors++;
                    $display("FAIL rr_deliver%0d: valid=%0b port=%0d expected 1/%0d",
                             c, cellValid, cellPort, (c - 1) % 4);
                end
            end
            tick();
        end
        #1;
        checks++;
        if (readEnable !== 1'b0 || cellValid !== 1'b1 || cellPort !== 2'd3 || cellData !== cell_of(5'd23)) begin
            errors++;
            $display("FAIL rr_last: en=%0b valid=%0b port=%0d data_ok=%0b expected 0/1/3/1",
                     readEnable, cellValid, cellPort, cellData === cell_of(5'd23));
        end
        tick();
        #1;
        checks++;
        if (queueCount !== 24'd0) begin
            errors++;
            $display("FAIL rr_drain: queueCount=%h expected 0", queueCount);
        end
    endtask

    task automatic test_tail_hazard();
        do_reset();
        link_mem[4] = 5'd8;
        enqValid = 1'b1; enqAddress = 5'd4; enqPort = 2'd1;
        tick();
        enqAddress = 5'd8;
        #1;
        checks++;
        if (readEnable !== 1'b0) begin
            errors++;
            $display("FAIL hazard_hold: readEnable=%0b expected 0", readEnable);
        end
        tick();
        enqValid = 1'b0;
        #1;
        checks++;
        if (readEnable !== 1'b1 || readAddress !== 5'd4 || readPort !== 2'd1 || qc(1) !== 6'd2) begin
            errors++;
            $display("FAIL hazard_old_head: en=%0b addr=%0d port=%0d cnt=%0d expected 1/4/1/2",
                     readEnable, readAddress, readPort, qc(1));
        end
        tick();
        #1;
        checks++;
        if (cellValid !== 1'b1 || cellData !== cell_of(5'd4) || readEnable !== 1'b0) begin
            errors++;
            $display("FAIL hazard_deliver: valid=%0b data_ok=%0b en=%0b expected 1/1/0",
                     cellValid, cellData === cell_of(5'd4), readEnable);
        end
        tick();
        #1;
        checks++;
        if (readEnable !== 1'b1 || readAddress !== 5'd8 || readPort !== 2'd1) begin
            errors++;
            $display("FAIL hazard_follow: en=%0b addr=%0d port=%0d expected 1/8/1", readEnable, readAddress, readPort);
        end
        tick();
        tick();
        #1;
        checks++;
        if (qc(1) !== 6'd0) begin
            errors++;
            $display("FAIL hazard_drain: cnt=%0d expected 0", qc(1));
        end
    endtask

    task automatic test_last_cell_refill();
        do_reset();
        link_mem[2] = 5'd31;
        enqValid = 1'b1; enqAddress = 5'd2; enqPort = 2'd3;
        tick();
        enqValid = 1'b0;
        #1;
        checks++;
        if (readEnable !== 1'b1 || readAddress !== 5'd2 || readPort !== 2'd3) begin
            errors++;
            $display("FAIL refill_issue: en=%0b addr=%0d port=%0d expected 1/2/3", readEnable, readAddress, readPort);
        end
        tick();
        enqValid = 1'b1; enqAddress = 5'd7; enqPort = 2'd3;
        #1;
        checks++;
        if (cellValid !== 1'b1 || cellPort !== 2'd3 || readEnable !== 1'b0) begin
            errors++;
            $display("FAIL refill_complete: valid=%0b port=%0d en=%0b expected 1/3/0", cellValid, cellPort, readEnable);
        end
        tick();
        enqValid = 1'b0;
        #1;
        checks++;
        if (qc(3) !== 6'd1 || readEnable !== 1'b1 || readAddress !== 5'd7 || readPort !== 2'd3) begin
            errors++;
            $display("FAIL refill_head: cnt=%0d en=%0b addr=%0d port=%0d expected 1/1/7/3",
                     qc(3), readEnable, readAddress, readPort);
        end
        tick();
        #1;
        checks++;
        if (cellValid !== 1'b1 || cellData !== cell_of(5'd7)) begin
            errors++;
            $display("FAIL refill_deliver: valid=%0b data_ok=%0b expected 1/1", cellValid, cellData === cell_of(5'd7));
        end
    endtask

    task automatic test_backpressure_reset();
        do_reset();
        link_mem[1] = 5'd6;
        portReady = 4'b1110;
        enqValid = 1'b1; enqAddress = 5'd1; enqPort = 2'd0;
        tick();
        enqAddress = 5'd6;
        tick();
        enqValid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (readEnable !== 1'b0 || qc(0) !== 6'd2) begin
                errors++;
                $display("FAIL bp_stall%0d: en=%0b cnt=%0d expected 0/2", c, readEnable, qc(0));
            end
            tick();
        end
        portReady = 4'hF;
        #1;
        checks++;
        if (readEnable !== 1'b1 || readAddress !== 5'd1 || readPort !== 2'd0) begin
            errors++;
            $display("FAIL bp_release: en=%0b addr=%0d port=%0d expected 1/1/0", readEnable, readAddress, readPort);
        end
        tick();
        #1;
        checks++;
        if (cellValid !== 1'b1 || cellData !== cell_of(5'd1)) begin
            errors++;
            $display("FAIL bp_deliver: valid=%0b data_ok=%0b expected 1/1", cellValid, cellData === cell_of(5'd1));
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (cellValid !== 1'b0 || cellData !== 512'd0 || queueCount !== 24'd0 || readEnable !== 1'b0) begin
            errors++;
            $display("FAIL bp_async_reset: valid=%0b data_nonzero=%0b queueCount=%h en=%0b expected 0/0/0/0",
                     cellValid, |cellData, queueCount, readEnable);
        end
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rstn       = 1'b0;
        enqValid   = 1'b0;
        enqAddress = '0;
        enqPort    = '0;
        portReady  = 4'hF;
        for (int i = 0; i < 32; i++) link_mem[i] = '0;

        test_reset();
        test_single_cell();
        test_linked_chain();
        test_round_robin();
        test_tail_hazard();
        test_last_cell_refill();
        test_backpressure_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
